// File: rtl/store_narrow_buffer.sv
// Store narrowing buffer: narrows GPR store data to byte/half/word lanes with byte enables and queues it for data memory.
// Latency: a store pushed into an empty buffer appears on mem_* right after the accepting edge. Otherwise it waits until all older entries have drained.
// Backpressure: st_ready drops when the buffer is full or flush is high. Head outputs hold steady while mem_ready is low.
// Ports:
//   clk, reset_n                  - clock (rising edge), async active-low reset
//   st_valid/st_ready             - store request handshake from the MEM stage
//   st_op, st_addr, st_data       - store opcode (00 SW, 01 SH, 10 SB, 11 illegal), byte address, GPR value
//   flush                         - synchronous discard of all queued stores
//   st_exc, st_exc_addr           - one-cycle reject pulse, and the address of the last rejected store
//   mem_valid/mem_ready           - head entry handshake to data memory
//   mem_addr, mem_wdata, mem_be   - word address, lane-replicated data, byte enables
//   count, empty                  - occupancy status
module store_narrow_buffer #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [1:0]       st_op,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic             flush,
  output logic             st_exc,
  output logic [31:0]      st_exc_addr,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_be,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Entry storage; only the word address is kept, since the byte offset lives in the enables.
  logic [29:0] ent_addr  [DEPTH];
  logic [31:0] ent_wdata [DEPTH];
  logic [3:0]  ent_be    [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;

  logic        legal;
  logic [31:0] nar_wdata;
  logic [3:0]  nar_be;
  logic        push;
  logic        pop;
  logic        reject;

  // Narrowing and alignment check for the incoming request
  always_comb begin
    legal     = 1'b0;
    nar_wdata = st_data;
    nar_be    = 4'b1111;
    case (st_op)
      2'b00: legal = (st_addr[1:0] == 2'b00);
      2'b01: begin
        legal     = ~st_addr[0];
        nar_wdata = {2{st_data[15:0]}};
        nar_be    = st_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        legal     = 1'b1;
        nar_wdata = {4{st_data[7:0]}};
        nar_be    = 4'b0001 << st_addr[1:0];
      end
      default: legal = 1'b0;
    endcase
  end

  // Readiness depends only on the registered count, so a pop cannot make room for a push in the same cycle.
  assign st_ready  = (count_q < CNT_W'(DEPTH)) & ~flush;
  assign push      = st_valid & st_ready & legal;
  assign reject    = st_valid & st_ready & ~legal;
  assign mem_valid = (count_q != '0);
  assign pop       = mem_valid & mem_ready;
  assign empty     = ~mem_valid;
  assign count     = count_q;

  // Head outputs read as zero when the buffer is empty, so stale storage never appears on the DM port.
  assign mem_addr  = mem_valid ? {ent_addr[rd_ptr], 2'b00} : 32'h0;
  assign mem_wdata = mem_valid ? ent_wdata[rd_ptr] : 32'h0;
  assign mem_be    = mem_valid ? ent_be[rd_ptr] : 4'h0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      st_exc      <= 1'b0;
      st_exc_addr <= 32'h0;
    end else begin
      st_exc <= reject;
      if (reject) begin
        st_exc_addr <= st_addr;
      end
      // A pop that coincides with flush has already completed on the DM side. Only the queue state is cleared.
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // The write slot never aliases the live head while the head is valid, so head data stays stable under stall.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[wr_ptr]  <= st_addr[31:2];
      ent_wdata[wr_ptr] <= nar_wdata;
      ent_be[wr_ptr]    <= nar_be;
    end
  end

endmodule
